// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; a single-digit datapath still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_add_sub_digit.sv
// One DIGIT-wide add/subtract slice; b is inverted when sign is set.
module add_sub_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             sign,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b ^ {DIGIT{sign}}} + {{DIGIT{1'b0}}, cin};
    assign s    = sum[DIGIT-1:0];
    assign cout = sum[DIGIT];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial x+y / x-y with valid/ready handshakes; one DIGIT slice per cycle, LSB first.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    input  logic             req_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_carry,
    output logic             rsp_ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t           state;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] acc;
    logic             sign_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt;

    int               off;
    logic [DIGIT-1:0] slice_x;
    logic [DIGIT-1:0] slice_y;
    logic [DIGIT-1:0] slice_s;
    logic             slice_cout;
    logic [WIDTH-1:0] acc_next;
    logic             last;
    logic             ovf_next;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign last      = (cnt == CW'(N - 1));

    always_comb begin
        off      = int'(cnt) * DIGIT;
        slice_x  = x_reg[off +: DIGIT];
        slice_y  = y_reg[off +: DIGIT];
        acc_next = acc;
        acc_next[off +: DIGIT] = slice_s;
        ovf_next = (x_reg[WIDTH-1] == (y_reg[WIDTH-1] ^ sign_reg)) &&
                   (acc_next[WIDTH-1] != x_reg[WIDTH-1]);
    end

    add_sub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (slice_x),
        .b    (slice_y),
        .sign (sign_reg),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // The result registers only change on the final RUN cycle, so rsp_z holds the previous result meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            acc       <= '0;
            sign_reg  <= 1'b0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            rsp_z     <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        x_reg     <= req_x;
                        y_reg     <= req_y;
                        sign_reg  <= req_sign;
                        carry_reg <= req_sign;
                        cnt       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc       <= acc_next;
                    carry_reg <= slice_cout;
                    cnt       <= cnt + CW'(1);
                    if (last) begin
                        rsp_z     <= acc_next;
                        rsp_carry <= slice_cout;
                        rsp_ovf   <= ovf_next;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: fixed vectors, backpressure, abort by reset, back-to-back random sweep.
module tb_serial_add_sub;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int N     = WIDTH / DIGIT;

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_x;
    logic [WIDTH-1:0] req_y;
    logic             req_sign;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z;
    logic             rsp_carry;
    logic             rsp_ovf;

    int               checks;
    int               failures;
    exp_t             sb[$];
    logic [WIDTH-1:0] last_z;

    serial_add_sub #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_carry (rsp_carry),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        exp_t           e;
        logic [WIDTH:0] full;
        logic [WIDTH:0] sx;
        logic [WIDTH:0] sy;
        logic [WIDTH:0] sz;
        if (s) full = {1'b0, x} - {1'b0, y};
        else   full = {1'b0, x} + {1'b0, y};
        e.z = full[WIDTH-1:0];
        e.c = s ? ~full[WIDTH] : full[WIDTH];
        sx  = {x[WIDTH-1], x};
        sy  = {y[WIDTH-1], y};
        sz  = s ? (sx - sy) : (sx + sy);
        e.o = (sz[WIDTH] != sz[WIDTH-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s, input exp_t e);
        req_x     = x;
        req_y     = y;
        req_sign  = s;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL accept_ready: req_ready=%b required 1", req_ready);
        end
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
        req_x     = $urandom;
        req_y     = $urandom;
        req_sign  = ~s;
    endtask

    task automatic collect(input string name);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != N) begin
            failures++;
            $display("[TB] FAIL %s_latency: got %0d cycles required %0d", name, cyc, N);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s_scoreboard: queue empty required 1 entry", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (rsp_z !== e.z) begin
                failures++;
                $display("[TB] FAIL %s_z: got %h required %h", name, rsp_z, e.z);
            end
            checks++;
            if (rsp_carry !== e.c) begin
                failures++;
                $display("[TB] FAIL %s_carry: got %b required %b", name, rsp_carry, e.c);
            end
            checks++;
            if (rsp_ovf !== e.o) begin
                failures++;
                $display("[TB] FAIL %s_ovf: got %b required %b", name, rsp_ovf, e.o);
            end
            last_z = e.z;
        end
    endtask

    task automatic finish_op(input string name);
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_to_idle: rsp_valid=%b req_ready=%b required 0/1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_x     = 32'h1;
        req_y     = 32'h2;
        req_sign  = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_handshake: req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
        end
        checks++;
        if (rsp_z !== '0 || rsp_carry !== 1'b0 || rsp_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: z=%h c=%b o=%b required 0/0/0", rsp_z, rsp_carry, rsp_ovf);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        last_z    = '0;
    endtask

    task automatic test_add();
        issue(32'hFFFF_FFFF, 32'h1, 1'b0, '{z: 32'h0, c: 1'b1, o: 1'b0});
        collect("add_wrap");
        finish_op("add_wrap");
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, '{z: 32'h8000_0000, c: 1'b0, o: 1'b1});
        collect("add_ovf");
        finish_op("add_ovf");
    endtask

    task automatic test_sub();
        issue(32'd5, 32'd7, 1'b1, '{z: 32'hFFFF_FFFE, c: 1'b0, o: 1'b0});
        collect("sub_borrow");
        finish_op("sub_borrow");
        issue(32'h8000_0000, 32'h1, 1'b1, '{z: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1});
        collect("sub_ovf");
        finish_op("sub_ovf");
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, '{z: 32'h2345_6789, c: 1'b0, o: 1'b0});
        collect("bp");
        req_x     = 32'd10;
        req_y     = 32'd5;
        req_sign  = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold_hs: rsp_valid=%b req_ready=%b required 1/0", rsp_valid, req_ready);
            end
            checks++;
            if (rsp_z !== 32'h2345_6789 || rsp_carry !== 1'b0 || rsp_ovf !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold_data: z=%h c=%b o=%b required 23456789/0/0", rsp_z, rsp_carry, rsp_ovf);
            end
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_release: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
        end
        issue(32'd10, 32'd5, 1'b1, '{z: 32'd5, c: 1'b1, o: 1'b0});
        collect("bp_next");
        finish_op("bp_next");
    endtask

    task automatic test_abort();
        issue(32'd100, 32'd200, 1'b0, model(32'd100, 32'd200, 1'b0));
        tick();
        checks++;
        if (rsp_z !== last_z || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL run_hold: z=%h rsp_valid=%b required %h/0", rsp_z, rsp_valid, last_z);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_z !== '0 || rsp_carry !== 1'b0 || rsp_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_outputs: rdy=%b vld=%b z=%h c=%b o=%b required 1/0/0/0/0",
                     req_ready, rsp_valid, rsp_z, rsp_carry, rsp_ovf);
        end
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_no_rsp: rsp_valid=%b required 0", rsp_valid);
            end
        end
        rst_n  = 1'b1;
        last_z = '0;
        issue(32'd3, 32'd4, 1'b0, '{z: 32'd7, c: 1'b0, o: 1'b0});
        collect("after_abort");
        finish_op("after_abort");
    endtask

    task automatic test_back_to_back();
        localparam int NOPS = 10;
        logic [WIDTH-1:0] xs[NOPS];
        logic [WIDTH-1:0] ys[NOPS];
        logic             ss[NOPS];
        int               k;
        int               got;
        int               cyc;
        int               last_cyc;
        exp_t             e;
        for (int i = 0; i < NOPS; i++) begin
            xs[i] = $urandom;
            ys[i] = $urandom;
            ss[i] = 1'($urandom_range(0, 1));
        end
        xs[1] = 32'h8000_0000;
        ys[1] = 32'h8000_0000;
        ss[1] = 1'b0;
        k         = 0;
        got       = 0;
        cyc       = 0;
        last_cyc  = -1;
        rsp_ready = 1'b1;
        req_x     = xs[0];
        req_y     = ys[0];
        req_sign  = ss[0];
        req_valid = 1'b1;
        while (got < NOPS && cyc < 300) begin
            if (req_valid && req_ready) begin
                sb.push_back(model(xs[k], ys[k], ss[k]));
                k++;
            end
            tick();
            cyc++;
            if (k < NOPS) begin
                req_x    = xs[k];
                req_y    = ys[k];
                req_sign = ss[k];
            end else begin
                req_valid = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL b2b_scoreboard: unexpected result z=%h", rsp_z);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (rsp_z !== e.z || rsp_carry !== e.c || rsp_ovf !== e.o) begin
                        failures++;
                        $display("[TB] FAIL b2b_result%0d: z=%h c=%b o=%b required %h/%b/%b",
                                 got, rsp_z, rsp_carry, rsp_ovf, e.z, e.c, e.o);
                    end
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != N + 2) begin
                        failures++;
                        $display("[TB] FAIL b2b_spacing: got %0d cycles required %0d", cyc - last_cyc, N + 2);
                    end
                end
                last_cyc = cyc;
                got++;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (got != NOPS) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d results required %0d", got, NOPS);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
